// File: rtl/can_tx_bus_selector_pkg.sv
// Shared types and constants for the CAN TX bus selector that drives the 1-to-32 demux.
package can_tx_bus_selector_pkg;

  localparam int DEF_SEL_W          = 5;
  localparam int NUM_BUS            = 2 ** DEF_SEL_W;
  localparam int DEF_GUARD_CYCLES   = 2;
  localparam int DEF_TIMEOUT_CYCLES = 4096;

  typedef enum logic [2:0] {
    ST_FLUSH,
    ST_IDLE,
    ST_PARK_PRE,
    ST_SWITCH,
    ST_ACTIVE,
    ST_PARK_POST
  } state_e;

  // The timer counts down from TIMEOUT_CYCLES-1 or GUARD_CYCLES-1, so it must hold the larger.
  function automatic int timer_width(int timeout_cycles, int guard_cycles);
    int w;
    w = $clog2(timeout_cycles);
    if ($clog2(guard_cycles) > w) w = $clog2(guard_cycles);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/can_tx_bus_selector_guard_timer.sv
// Loadable down-counter shared by the guard windows and the ACTIVE timeout; saturates at zero.
module can_tx_guard_timer #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count_q, count_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/can_tx_bus_selector.sv
// Routes the TX controller's serial bit to one of 2**SEL_W demux outputs, changing sel only
// while the routed bit is recessive so every unselected bus stays latched at 1.
module can_tx_bus_selector
  import can_tx_bus_selector_pkg::*;
#(
  parameter int SEL_W          = DEF_SEL_W,
  parameter int GUARD_CYCLES   = DEF_GUARD_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [SEL_W-1:0] req_bus_id,
  output logic             req_ready,
  input  logic             tx_active,
  input  logic             tx_bit,
  output logic [SEL_W-1:0] sel,
  output logic             tx_out,
  output logic             busy,
  output logic             done,
  output logic             timeout
);

  localparam int               CNT_W        = timer_width(TIMEOUT_CYCLES, GUARD_CYCLES);
  localparam logic [SEL_W-1:0] LAST_SEL     = SEL_W'((1 << SEL_W) - 1);
  localparam logic [CNT_W-1:0] GUARD_LOAD   = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d, id_q, id_d;
  logic             tx_out_q, tx_out_d;
  logic             req_ready_q, req_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             to_flag_q, to_flag_d;
  logic             timer_load, timer_expired;
  logic [CNT_W-1:0] timer_load_val;

  can_tx_guard_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_load_val),
    .expired  (timer_expired)
  );

  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    id_d           = id_q;
    to_flag_d      = to_flag_q;
    tx_out_d       = 1'b1;
    done_d         = 1'b0;
    timeout_d      = 1'b0;
    timer_load     = 1'b0;
    timer_load_val = GUARD_LOAD;

    unique case (state_q)
      ST_FLUSH: begin
        if (sel_q == LAST_SEL) state_d = ST_IDLE;
        else                   sel_d   = sel_q + SEL_W'(1);
      end
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          id_d       = req_bus_id;
          state_d    = ST_PARK_PRE;
          timer_load = 1'b1;
        end
      end
      ST_PARK_PRE: begin
        if (timer_expired) state_d = ST_SWITCH;
      end
      ST_SWITCH: begin
        sel_d          = id_q;
        state_d        = ST_ACTIVE;
        timer_load     = 1'b1;
        timer_load_val = TIMEOUT_LOAD;
      end
      ST_ACTIVE: begin
        // A frame ending on the timeout cycle is a normal end, hence tx_active is tested first.
        if (!tx_active) begin
          state_d    = ST_PARK_POST;
          timer_load = 1'b1;
        end else if (timer_expired) begin
          state_d    = ST_PARK_POST;
          timer_load = 1'b1;
          to_flag_d  = 1'b1;
        end else begin
          tx_out_d = tx_bit;
        end
      end
      ST_PARK_POST: begin
        if (timer_expired) begin
          state_d   = ST_IDLE;
          done_d    = 1'b1;
          timeout_d = to_flag_q;
          to_flag_d = 1'b0;
        end
      end
      default: state_d = ST_FLUSH;
    endcase

    req_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FLUSH;
      sel_q       <= '0;
      id_q        <= '0;
      tx_out_q    <= 1'b1;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      to_flag_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      id_q        <= id_d;
      tx_out_q    <= tx_out_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      to_flag_q   <= to_flag_d;
    end
  end

  assign sel       = sel_q;
  assign tx_out    = tx_out_q;
  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_can_tx_bus_selector.sv
// Directed/randomized bench: a timeline model predicts every output cycle of each routing window.
module tb_can_tx_bus_selector;
  import can_tx_bus_selector_pkg::*;

  localparam int G  = 2;
  localparam int TA = 4096;
  localparam int TB = 16;

  typedef struct packed {
    logic [4:0] sel;
    logic       tx;
    logic       rdy;
    logic       busy;
    logic       done;
    logic       to;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [4:0] req_bus_id;
  logic       tx_active, tx_bit;

  logic [4:0] sel_a, sel_b;
  logic       tx_out_a, tx_out_b, req_ready_a, req_ready_b, busy_a, busy_b;
  logic       done_a, done_b, timeout_a, timeout_b;

  int          total = 0;
  int          bad   = 0;
  obs_t        prev_obs [2];
  logic [31:0] dmx      [2];
  logic [4:0]  exp_sel  [2];

  always #5 clk = ~clk;

  can_tx_bus_selector #(.SEL_W(5), .GUARD_CYCLES(G), .TIMEOUT_CYCLES(TA)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_bus_id(req_bus_id),
    .req_ready(req_ready_a), .tx_active(tx_active), .tx_bit(tx_bit), .sel(sel_a),
    .tx_out(tx_out_a), .busy(busy_a), .done(done_a), .timeout(timeout_a)
  );

  can_tx_bus_selector #(.SEL_W(5), .GUARD_CYCLES(G), .TIMEOUT_CYCLES(TB)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_bus_id(req_bus_id),
    .req_ready(req_ready_b), .tx_active(tx_active), .tx_bit(tx_bit), .sel(sel_b),
    .tx_out(tx_out_b), .busy(busy_b), .done(done_b), .timeout(timeout_b)
  );

  function automatic obs_t get_obs(int d);
    if (d == 0) return {sel_a, tx_out_a, req_ready_a, busy_a, done_a, timeout_a};
    return {sel_b, tx_out_b, req_ready_b, busy_b, done_b, timeout_b};
  endfunction

  function automatic obs_t mk(logic [4:0] s, logic tx, logic r, logic b, logic dn, logic to);
    return {s, tx, r, b, dn, to};
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock; afterwards, per DUT: sel may only have moved across two recessive cycles, and
  // the demux model latches tx_out into the selected output.
  task automatic step();
    logic r;
    obs_t o;
    r = rst;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      o = get_obs(d);
      if (!r && o.sel != prev_obs[d].sel)
        check($sformatf("sel_change_recessive dut%0d", d), {30'b0, prev_obs[d].tx, o.tx}, 32'd3);
      dmx[d][o.sel] = o.tx;
      prev_obs[d]   = o;
    end
  endtask

  // Entered on the first cycle after reset; requests are offered throughout and must be ignored.
  task automatic flush_check();
    for (int i = 0; i < NUM_BUS; i++) begin
      for (int d = 0; d < 2; d++)
        check($sformatf("flush dut%0d i=%0d", d, i), 32'(get_obs(d)), 32'(mk(5'(i), 1, 0, 1, 0, 0)));
      req_valid  = 2'b11;
      req_bus_id = 5'($urandom);
      tx_active  = 1'($urandom);
      tx_bit     = 1'($urandom);
      step();
    end
    req_valid = 2'b00;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("flush_to_idle dut%0d", d), 32'(get_obs(d)), 32'(mk(5'd31, 1, 1, 0, 0, 0)));
      check($sformatf("flush_demux dut%0d", d), dmx[d], 32'hFFFF_FFFF);
      exp_sel[d] = 5'd31;
    end
  endtask

  // Called on an IDLE cycle of DUT d. Frame of f bits: tx_active high for ACTIVE cycles 0..f-1,
  // low on cycle f. ACTIVE lasts min(f+1, t) cycles; timeout iff f >= t.
  task automatic run_txn(int d, logic [4:0] b, int f, int t, bit hold, logic [4:0] nxt,
                         int abort_k, bit zero_bits);
    int         len, jend;
    bit         to;
    bit         bits[$];
    logic [4:0] s0;
    s0  = exp_sel[d];
    len = (f + 1 < t) ? f + 1 : t;
    to  = (f >= t);
    for (int i = 0; i < f; i++) bits.push_back(zero_bits ? 1'b0 : 1'($urandom));
    req_valid[d] = 1'b1;
    req_bus_id   = b;
    tx_active    = 1'($urandom);
    tx_bit       = 1'($urandom);
    step();
    if (hold) req_bus_id = nxt;
    else      req_valid[d] = 1'b0;
    jend = 2 * G + 2 + len;
    for (int j = 1; j <= jend; j++) begin
      int   k;
      obs_t e;
      k = j - (G + 2);
      if (j <= G + 1)    e = mk(s0, 1, 0, 1, 0, 0);
      else if (k < len)  e = mk(b, (k == 0) ? 1'b1 : bits[k-1], 0, 1, 0, 0);
      else if (j < jend) e = mk(b, 1, 0, 1, 0, 0);
      else               e = mk(b, 1, 1, 0, 1, to);
      check($sformatf("txn dut%0d bus=%0d j=%0d", d, b, j), 32'(get_obs(d)), 32'(e));
      if (k >= 0 && k < f) begin
        tx_active = 1'b1;
        tx_bit    = bits[k];
      end else if (k == f) begin
        tx_active = 1'b0;
        tx_bit    = 1'($urandom);
      end else begin
        tx_active = 1'($urandom);
        tx_bit    = 1'($urandom);
      end
      if (abort_k >= 0 && k == abort_k) begin
        check("demux_dominant_before_rst", {31'b0, dmx[d][b]}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("reset_mid_active", 32'(get_obs(d)), 32'(mk(5'd0, 1, 0, 1, 0, 0)));
        return;
      end
      if (j < jend) step();
    end
    exp_sel[d] = b;
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 2'b00;
    req_bus_id = '0;
    tx_active  = 1'b0;
    tx_bit     = 1'b1;
    prev_obs[0] = '0;
    prev_obs[1] = '0;
    dmx[0]      = '0;
    dmx[1]      = '0;

    step();
    for (int d = 0; d < 2; d++)
      check($sformatf("reset dut%0d", d), 32'(get_obs(d)), 32'(mk(5'd0, 1, 0, 1, 0, 0)));
    step();
    rst = 1'b0;
    flush_check();

    // Bus 7, 20-bit frame
    run_txn(0, 5'd7, 20, TA, 0, 5'd0, -1, 0);
    // Back-to-back 3 then 28 with req_valid held high, then a repeat of the current bus
    run_txn(0, 5'd3, 12, TA, 1, 5'd28, -1, 0);
    run_txn(0, 5'd28, 9, TA, 0, 5'd0, -1, 0);
    run_txn(0, 5'd28, 5, TA, 0, 5'd0, -1, 0);
    // Short frames, including an immediate end
    run_txn(0, 5'd0, 0, TA, 0, 5'd0, -1, 0);
    run_txn(0, 5'd31, 1, TA, 0, 5'd0, -1, 0);
    for (int i = 0; i < 4; i++)
      run_txn(0, 5'($urandom), $urandom_range(0, 40), TA, 0, 5'd0, -1, 0);

    // Short-timeout instance: stuck frame, end on the timeout cycle, one past it
    run_txn(1, 5'd5, 40, TB, 0, 5'd0, -1, 1);
    run_txn(1, 5'd9, 15, TB, 0, 5'd0, -1, 0);
    run_txn(1, 5'd9, 16, TB, 1, 5'd20, -1, 0);
    run_txn(1, 5'd20, 14, TB, 0, 5'd0, -1, 0);
    for (int i = 0; i < 3; i++)
      run_txn(1, 5'($urandom), $urandom_range(0, 25), TB, 0, 5'd0, -1, 0);

    // Reset while bus 12 is dominant; the flush must restore it
    run_txn(0, 5'd12, 20, TA, 0, 5'd0, 5, 1);
    flush_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
